// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_tx serial framing transmitter and its s2p receiver.
package p2s_pkg;

   localparam int unsigned P2S_WIDTH_DEF = 8;

   typedef enum logic {
      P2S_IDLE  = 1'b0,
      P2S_SHIFT = 1'b1
   } p2s_state_e;

endpackage : p2s_pkg

// File: rtl/p2s_hold_reg.sv
// One-word holding register: load a word, report full, release it on take.
module p2s_hold_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             take,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout <= '0;
         full <= 1'b0;
      end else if (load) begin
         dout <= din;
         full <= 1'b1;
      end else if (take) begin
         dout <= '0;
         full <= 1'b0;
      end
   end

endmodule : p2s_hold_reg

// File: rtl/p2s_tx.sv
// Parallel-to-serial framing transmitter, MSB first, sync on the first bit of each frame.
// Optional one-word holding register enabled by defining P2S_HOLD_EN.
module p2s_tx
   import p2s_pkg::*;
#(
   parameter int unsigned WIDTH = P2S_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] datain,
   input  logic             valid,
   output logic             ack,
   output logic             dataout,
   output logic             sync,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);

   p2s_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             last;
   logic             xfer;

   assign last = (state_q == P2S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
   assign xfer = valid && ack;

`ifdef P2S_HOLD_EN
   logic             hold_load;
   logic             hold_take;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;

   // Mid-frame transfers park in the hold; IDLE and last-bit transfers bypass it.
   assign hold_load = xfer && (state_q == P2S_SHIFT) && !last;
   assign ack       = !hold_full;

   p2s_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (hold_load),
      .din     (datain),
      .take    (hold_take),
      .dout    (hold_data),
      .full    (hold_full)
   );
`else
   assign ack = (state_q == P2S_IDLE) || last;
`endif

   // Wire outputs are pure decodes of the state registers.
   assign busy    = (state_q == P2S_SHIFT);
   assign dataout = busy && sh_q[WIDTH-1];
   assign sync    = busy && (cnt_q == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= P2S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
`ifdef P2S_HOLD_EN
      hold_take = 1'b0;
`endif
      case (state_q)
         P2S_IDLE: begin
            if (xfer) begin
               sh_d    = datain;
               cnt_d   = '0;
               state_d = P2S_SHIFT;
            end
         end
         P2S_SHIFT: begin
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               cnt_d = '0;
`ifdef P2S_HOLD_EN
               if (hold_full) begin
                  sh_d      = hold_data;
                  hold_take = 1'b1;
               end else
`endif
               if (xfer) begin
                  sh_d = datain;
               end else begin
                  state_d = P2S_IDLE;
               end
            end
         end
         default: state_d = P2S_IDLE;
      endcase
   end

endmodule : p2s_tx

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: directed frames plus random words against a bit-queue line model.
module tb_p2s_tx;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] datain = '0;
   logic         valid = 1'b0;
   logic         ack;
   logic         dataout;
   logic         sync;
   logic         busy;

   int total = 0;
   int bad   = 0;

   // Line model: each entry is {sync, bit} still to appear on the wire; front is on the wire now.
   logic [1:0]   line_q[$];
   logic [W-1:0] sent_q[$];
   logic [W-1:0] rx_word = '0;
   int           rx_cnt  = 0;
   bit           last_xfer = 1'b0;

   p2s_tx #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .datain  (datain),
      .valid   (valid),
      .ack     (ack),
      .dataout (dataout),
      .sync    (sync),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Acceptance capacity: one word beyond the frame on the wire with the hold, else only at the end.
   function automatic bit model_ack();
`ifdef P2S_HOLD_EN
      return line_q.size() <= W;
`else
      return line_q.size() <= 1;
`endif
   endfunction

   task automatic check_wire();
      logic exp_bit, exp_sync, exp_busy;
      exp_busy = line_q.size() > 0;
      exp_bit  = exp_busy ? line_q[0][0] : 1'b0;
      exp_sync = exp_busy ? line_q[0][1] : 1'b0;
      check("dataout", 32'(dataout), 32'(exp_bit));
      check("sync",    32'(sync),    32'(exp_sync));
      check("busy",    32'(busy),    32'(exp_busy));
      check("ack",     32'(ack),     32'(model_ack()));
      // Receiver view: rebuild words from the wire and compare in order.
      if (busy) begin
         if (sync) rx_cnt = 0;
         rx_word = {rx_word[W-2:0], dataout};
         rx_cnt++;
         if (rx_cnt == W) begin
            if (sent_q.size() == 0) check("rx_underflow", 32'(rx_word), 32'hDEAD);
            else check("rx_word", 32'(rx_word), 32'(sent_q.pop_front()));
            rx_cnt = 0;
         end
      end
   endtask

   task automatic cycle();
      bit xfer;
      xfer = valid && model_ack();
      @(posedge clk);
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (xfer) begin
         for (int i = W - 1; i >= 0; i--)
            line_q.push_back({(i == W - 1) ? 1'b1 : 1'b0, datain[i]});
         sent_q.push_back(datain);
      end
      last_xfer = xfer;
      @(negedge clk);
      check_wire();
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Present a word and hold it until accepted; valid is left high for the caller.
   task automatic offer(input logic [W-1:0] w);
      bit done;
      done   = 1'b0;
      valid  = 1'b1;
      datain = w;
      for (int i = 0; i < 4 * W && !done; i++) begin
         cycle();
         done = last_xfer;
      end
      if (!done) check("offer_timeout", 32'(0), 32'(1));
   endtask

   task automatic flush_model();
      line_q.delete();
      sent_q.delete();
      rx_cnt = 0;
   endtask

   initial begin
      logic [W-1:0] w;
      // Reset state
      #1;
      check("rst_dataout", 32'(dataout), 32'(0));
      check("rst_sync",    32'(sync),    32'(0));
      check("rst_busy",    32'(busy),    32'(0));
      check("rst_ack",     32'(ack),     32'(1));
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Single word
      offer(8'hB3);
      idle(W + 3);

      // Back-to-back with valid held
      offer(8'hB3);
      offer(8'hE1);
      idle(2 * W + 2);

      // Mid-frame offer: stall without the hold, parked in the hold otherwise
      offer(8'hB3);
      idle(2);
      offer(8'h5A);
      idle(2 * W + 2);

      // Reset mid-frame
      offer(8'hB3);
      idle(4);
      #1 reset_n = 1'b0;
      #1;
      check("arst_dataout", 32'(dataout), 32'(0));
      check("arst_sync",    32'(sync),    32'(0));
      check("arst_busy",    32'(busy),    32'(0));
      check("arst_ack",     32'(ack),     32'(1));
      flush_model();
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);
      offer(8'h0F);
      idle(W + 2);

      // Random words with random gaps
      for (int k = 0; k < 20; k++) begin
         w = W'($urandom);
         offer(w);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
      end
      idle(3 * W);
      check("rx_all_received", 32'(sent_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_p2s_tx

// File: doc/p2s_tx.md
# p2s_tx

Parallel-to-serial framing transmitter: the sending end of the serial link consumed by the `s2p` receiver. Accepts `WIDTH`-bit words from an upstream producer over a valid/ack handshake. Emits each word MSB first, one bit per clock, on `dataout`, with `sync` high during the first bit of every frame. Sits between the packet/word source and the serial pins, and produces frames with zero inter-frame gap when fed continuously.

## Interface
- `WIDTH`, default 8: word and frame length in bits; legal range ≥ 2.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `datain`  in  `WIDTH`: word to transmit; must be stable while `valid` is high and the word is not yet accepted.
- `valid`  in  1: producer offers `datain`.
- `ack`  out  1: block accepts `datain` at the next rising edge if `valid` is high. Driven only from registers, with no combinational path from `valid`.
- `dataout`  out  1: serial data, MSB first.
- `sync`  out  1: high for exactly the first bit cycle of each frame.
- `busy`  out  1: high while a frame is on the wire.

## Operation
- Transfer: occurs on a rising edge with `valid && ack`. Otherwise `datain` is ignored.
- FSM has two states: IDLE and SHIFT, with a bit counter `cnt` of width `$clog2(WIDTH)`.
- IDLE:
  - `ack`=1, `busy`=0, `dataout`=0, `sync`=0.
  - On transfer: load the shift register and go to SHIFT with `cnt`=0.
- SHIFT:
  - `dataout` = shift register MSB; `busy`=1; `sync` = (`cnt`==0).
  - Each edge: shift left by 1 and increment `cnt`.
- Last bit (`cnt`==`WIDTH`-1):
  - With a new word available (transfer, or hold register full when `P2S_HOLD_EN` is defined): load it, set `cnt`=0, stay in SHIFT. The next frame starts with `sync`=1 with no gap.
  - Otherwise: return to IDLE.
- `ack` without the hold: `ack` = IDLE || (SHIFT && `cnt`==`WIDTH`-1).
- Reset (async, any time):
  - State → IDLE; `cnt`, shift register and hold cleared.
  - `dataout`=0, `sync`=0, `busy`=0, `ack`=1.
  - A frame in progress is truncated and never resumed. A word sitting in the hold register is discarded.

## Timing
- A transfer at edge E0 places bit `WIDTH`-1 on `dataout` in the cycle after E0, with `sync`=1. Bit 0 appears in the cycle after E0+(`WIDTH`-1).
- Latency from acceptance to first bit: 1 cycle. Frame length: exactly `WIDTH` cycles.
- Continuous `valid` gives 100% line utilisation: one word per `WIDTH` cycles.
- Producer rule: hold `valid` and `datain` stable until an edge where `ack`=1. After the transfer, the producer either deasserts `valid` or presents the next word in the same cycle.
- `valid` dropping without a transfer is legal and has no effect.

## Configuration
- Macro: `P2S_HOLD_EN`.
- Defined: adds a one-word holding register.
  - `ack` = !`hold_full`.
  - A transfer while SHIFT is not at its last bit goes into the hold register.
  - A transfer in IDLE, or at the last bit with the hold empty, goes straight to the shifter.
  - At the last bit with the hold full: hold → shifter, and the hold is cleared.
  - Effect: the producer is released up to `WIDTH`-1 cycles early.
- Undefined: no hold register; `ack` follows the rule in Operation; wire behaviour is otherwise identical.

## Structure
- Package `p2s_pkg`:
  - state enum (`P2S_IDLE`, `P2S_SHIFT`);
  - `P2S_WIDTH_DEF` = 8, used as the `WIDTH` default;
  - shared with the `s2p` receiver so frame length stays consistent.
- Sub-module `p2s_hold_reg`: the one-word holding register with load/take/full. Instantiated only under `P2S_HOLD_EN`.

## Test plan
- Single word: `datain`=8'hB3, `valid` for one accepted edge → `dataout` 1,0,1,1,0,0,1,1 on 8 consecutive cycles; `sync`=1 only on the first; then IDLE with `dataout`=0 and `busy`=0.
- Back-to-back: 8'hB3 then 8'hE1, `valid` held → 16 contiguous bits; `sync` high on cycles 1 and 9; `ack` high only at accept points (without `P2S_HOLD_EN`).
- Hold path (`P2S_HOLD_EN`): 8'hB3 accepted, then 8'h5A offered 2 cycles later → accepted immediately and `ack` drops; 8'h5A starts with `sync` directly after bit 0 of 8'hB3; `ack` returns to 1 when the hold drains.
- Stall: `valid` raised mid-frame (no hold) → `ack`=0 until the last bit; transfer on that edge; no gap before the new `sync`.
- Reset mid-frame: `reset_n` low at bit 4 of 8'hB3 → `dataout`, `sync` and `busy` go to 0 asynchronously. After release, 8'h0F is sent cleanly with `sync` on its first bit.
- Loopback: `p2s_tx` → `s2p` with 20 random words → all words received in order with no loss.
